// File: rtl/usb_ctl_arbiter_if.sv
// Control-endpoint bundle between usb_xfer, usb_ctl_arbiter and the request handlers.
// master = arbiter view, slave = usb_xfer plus handler side.
interface usb_ctl_arbiter_if #(
  parameter int N_HND = 2
);
  logic                 xfer_req_i;
  logic                 xfer_gnt_o;
  logic                 xfer_done_o;
  logic                 xfer_stall_o;
  logic                 xfer_dvalid_i;
  logic                 xfer_tvalid_o;
  logic                 xfer_tlast_o;
  logic [7:0]           xfer_tdata_o;
  logic                 xfer_tready_i;
  logic [N_HND-1:0]     hnd_claim_i;
  logic [N_HND-1:0]     hnd_req_o;
  logic [N_HND-1:0]     hnd_gnt_i;
  logic [N_HND-1:0]     hnd_done_i;
  logic [N_HND-1:0]     hnd_dvalid_o;
  logic [N_HND-1:0]     hnd_tvalid_i;
  logic [N_HND-1:0]     hnd_tlast_i;
  logic [8*N_HND-1:0]   hnd_tdata_i;
  logic [N_HND-1:0]     hnd_tready_o;

  modport master (
    input  xfer_req_i, xfer_dvalid_i, xfer_tready_i,
    input  hnd_claim_i, hnd_gnt_i, hnd_done_i, hnd_tvalid_i, hnd_tlast_i, hnd_tdata_i,
    output xfer_gnt_o, xfer_done_o, xfer_stall_o, xfer_tvalid_o, xfer_tlast_o, xfer_tdata_o,
    output hnd_req_o, hnd_dvalid_o, hnd_tready_o
  );

  modport slave (
    output xfer_req_i, xfer_dvalid_i, xfer_tready_i,
    output hnd_claim_i, hnd_gnt_i, hnd_done_i, hnd_tvalid_i, hnd_tlast_i, hnd_tdata_i,
    input  xfer_gnt_o, xfer_done_o, xfer_stall_o, xfer_tvalid_o, xfer_tlast_o, xfer_tdata_o,
    input  hnd_req_o, hnd_dvalid_o, hnd_tready_o
  );
endinterface

// File: rtl/usb_ctl_arbiter.sv
// N-way control-request arbiter: claim window, lowest-index ownership, STALL when unclaimed.
// Optional owner-accept watchdog enabled by defining USB_CTL_ARB_WATCHDOG_EN.
module usb_ctl_arbiter #(
  parameter int N_HND        = 2,
  parameter int CLAIM_CYCLES = 2,
  parameter int GNT_TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset_n,
  usb_ctl_arbiter_if.master   ctl_if,
  output logic [2:0]          owner_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLAIM = 2'd1,
    ST_OWN   = 2'd2,
    ST_STALL = 2'd3
  } state_t;

  if (N_HND < 2 || N_HND > 8 || CLAIM_CYCLES < 1 || CLAIM_CYCLES > 15 ||
      GNT_TIMEOUT < 1 || GNT_TIMEOUT > 65535) begin : g_bad_cfg
    $error("usb_ctl_arbiter: parameter out of range");
  end

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [N_HND-1:0]   claim_q, claim_d;
  logic [2:0]         owner_q, owner_d;
`ifdef USB_CTL_ARB_WATCHDOG_EN
  logic [15:0]        wd_q, wd_d;
`endif

  logic [N_HND-1:0]   own_sel_s;
  logic [N_HND-1:0]   claim_all_s;
  logic [2:0]         first_idx_s;
  logic [7:0]         tdata_sel_s;
  logic               gnt_sel_s;

  // Owner decode, priority pick over accumulated claims and owner data mux.
  always_comb begin
    claim_all_s = claim_q | ctl_if.hnd_claim_i;
    first_idx_s = 3'd0;
    tdata_sel_s = 8'h00;
    own_sel_s   = '0;
    for (int i = N_HND - 1; i >= 0; i--) begin
      first_idx_s = claim_all_s[i] ? 3'(i) : first_idx_s;
    end
    for (int i = 0; i < N_HND; i++) begin
      own_sel_s[i] = (owner_q == 3'(i));
      tdata_sel_s  = tdata_sel_s | (ctl_if.hnd_tdata_i[8*i +: 8] & {8{own_sel_s[i]}});
    end
    gnt_sel_s = |(ctl_if.hnd_gnt_i & own_sel_s);
  end

  // Next-state logic and owner-only routing of handshake and stream signals.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    claim_d = claim_q;
    owner_d = owner_q;
`ifdef USB_CTL_ARB_WATCHDOG_EN
    wd_d    = wd_q;
`endif
    ctl_if.xfer_gnt_o    = 1'b0;
    ctl_if.xfer_done_o   = 1'b0;
    ctl_if.xfer_stall_o  = 1'b0;
    ctl_if.xfer_tvalid_o = 1'b0;
    ctl_if.xfer_tlast_o  = 1'b0;
    ctl_if.xfer_tdata_o  = 8'h00;
    ctl_if.hnd_req_o     = '0;
    ctl_if.hnd_dvalid_o  = '0;
    ctl_if.hnd_tready_o  = '0;

    case (state_q)
      ST_IDLE: begin
        if (ctl_if.xfer_req_i) begin
          state_d = ST_CLAIM;
          cnt_d   = 4'd0;
          claim_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLAIM: begin
        if (!ctl_if.xfer_req_i) begin
          state_d = ST_IDLE;
          claim_d = '0;
        end else if (cnt_q == 4'(CLAIM_CYCLES - 1)) begin
          claim_d = claim_all_s;
          if (|claim_all_s) begin
            owner_d = first_idx_s;
            state_d = ST_OWN;
`ifdef USB_CTL_ARB_WATCHDOG_EN
            wd_d    = 16'd0;
`endif
          end else begin
            state_d = ST_STALL;
          end
        end else begin
          cnt_d   = cnt_q + 4'd1;
          claim_d = claim_all_s;
        end
      end

      ST_OWN: begin
        ctl_if.hnd_req_o     = own_sel_s & {N_HND{ctl_if.xfer_req_i}};
        ctl_if.xfer_gnt_o    = gnt_sel_s;
        ctl_if.xfer_done_o   = |(ctl_if.hnd_done_i & own_sel_s);
        ctl_if.xfer_tvalid_o = |(ctl_if.hnd_tvalid_i & own_sel_s);
        ctl_if.xfer_tlast_o  = |(ctl_if.hnd_tlast_i & own_sel_s);
        ctl_if.xfer_tdata_o  = tdata_sel_s;
        ctl_if.hnd_tready_o  = own_sel_s & {N_HND{ctl_if.xfer_tready_i}};
        ctl_if.hnd_dvalid_o  = own_sel_s & {N_HND{ctl_if.xfer_dvalid_i}};
        if (!ctl_if.xfer_req_i) begin
          state_d = ST_IDLE;
        end else begin
`ifdef USB_CTL_ARB_WATCHDOG_EN
          // The owner's request is withdrawn in the same cycle the timeout fires.
          if (gnt_sel_s) begin
            wd_d = wd_q;
          end else if (wd_q == 16'(GNT_TIMEOUT - 1)) begin
            ctl_if.hnd_req_o = '0;
            state_d          = ST_STALL;
          end else begin
            wd_d = wd_q + 16'd1;
          end
`else
          state_d = ST_OWN;
`endif
        end
      end

      ST_STALL: begin
        ctl_if.xfer_stall_o = 1'b1;
        ctl_if.xfer_done_o  = 1'b1;
        if (!ctl_if.xfer_req_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STALL;
        end
      end

      default: begin
        state_d = ST_IDLE;
        claim_d = '0;
      end
    endcase
  end

  // State, claim window and owner registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      claim_q <= '0;
      owner_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      claim_q <= claim_d;
      owner_q <= owner_d;
    end
  end

`ifdef USB_CTL_ARB_WATCHDOG_EN
  // Owner-accept watchdog counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= 16'd0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign owner_o = owner_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_ctl_arbiter.sv
// Directed bench for usb_ctl_arbiter with N_HND=3, CLAIM_CYCLES=2, GNT_TIMEOUT=16.
module tb_usb_ctl_arbiter;
  localparam int N = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] owner_o;
  logic       busy_o;

  always #5 clock = ~clock;

  usb_ctl_arbiter_if #(.N_HND(N)) bus ();

  usb_ctl_arbiter #(.N_HND(N), .CLAIM_CYCLES(2), .GNT_TIMEOUT(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ctl_if  (bus),
    .owner_o (owner_o),
    .busy_o  (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.xfer_req_i    = 1'b0;
    bus.xfer_dvalid_i = 1'b0;
    bus.xfer_tready_i = 1'b0;
    bus.hnd_claim_i   = 3'b000;
    bus.hnd_gnt_i     = 3'b000;
    bus.hnd_done_i    = 3'b000;
    bus.hnd_tvalid_i  = 3'b000;
    bus.hnd_tlast_i   = 3'b000;
    bus.hnd_tdata_i   = 24'h000000;
  endtask

  // {gnt, done, stall, tvalid, tlast}
  function automatic logic [4:0] xfer_flags();
    return {bus.xfer_gnt_o, bus.xfer_done_o, bus.xfer_stall_o, bus.xfer_tvalid_o, bus.xfer_tlast_o};
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ptr, got, bad, cyc;
    logic adv;

    idle_inputs();
    #12;
    settle();
    check_eq("rst_busy",  32'(busy_o), 32'h0);
    check_eq("rst_owner", 32'(owner_o), 32'h0);
    check_eq("rst_flags", 32'(xfer_flags()), 32'h0);
    check_eq("rst_hreq",  32'(bus.hnd_req_o), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Handlers 1 and 2 claim; handler 1 wins.
    bus.xfer_req_i  = 1'b1;
    bus.hnd_claim_i = 3'b110;
    tick(); settle();
    check_eq("claim_busy", 32'(busy_o), 32'h1);
    check_eq("claim_hreq1", 32'(bus.hnd_req_o), 32'h0);
    tick(); settle();
    check_eq("claim_hreq2", 32'(bus.hnd_req_o), 32'h0);
    check_eq("claim_flags", 32'(xfer_flags()), 32'h0);
    tick();
    bus.hnd_claim_i = 3'b001;
    settle();
    check_eq("own_owner", 32'(owner_o), 32'h1);
    check_eq("own_hreq",  32'(bus.hnd_req_o), 32'h2);
    check_eq("own_stall", 32'(bus.xfer_stall_o), 32'h0);
    bus.hnd_gnt_i = 3'b100;
    settle();
    check_eq("gnt_nonowner", 32'(bus.xfer_gnt_o), 32'h0);
    bus.hnd_gnt_i = 3'b010;
    settle();
    check_eq("gnt_owner", 32'(bus.xfer_gnt_o), 32'h1);
    bus.hnd_done_i = 3'b101;
    settle();
    check_eq("done_nonowner", 32'(bus.xfer_done_o), 32'h0);
    bus.hnd_done_i = 3'b000;
    bus.xfer_dvalid_i = 1'b1;
    settle();
    check_eq("dvalid_route", 32'(bus.hnd_dvalid_o), 32'h2);
    bus.xfer_dvalid_i = 1'b0;

    // 18-byte IN stream from handler 1; handler 2 drives junk.
    bus.hnd_tvalid_i[2] = 1'b1;
    bus.hnd_tdata_i[23:16] = 8'hEE;
    bus.xfer_tready_i = 1'b1;
    for (int k = 0; k < 18; k++) begin
      bus.hnd_tvalid_i[1]   = 1'b1;
      bus.hnd_tlast_i[1]    = (k == 17);
      bus.hnd_tdata_i[15:8] = 8'(8'h40 + k);
      settle();
      check_eq($sformatf("s18_beat%0d", k),
               32'({bus.xfer_tvalid_o, bus.xfer_tlast_o, bus.xfer_tdata_o}),
               32'({1'b1, (k == 17), 8'(8'h40 + k)}));
      check_eq($sformatf("s18_tready%0d", k), 32'(bus.hnd_tready_o), 32'h2);
      tick();
    end
    idle_inputs();
    settle();
    check_eq("own_reqfall_hreq", 32'(bus.hnd_req_o), 32'h0);
    tick(); settle();
    check_eq("own_end_busy", 32'(busy_o), 32'h0);
    check_eq("own_end_owner", 32'(owner_o), 32'h1);

    // Unclaimed request -> STALL.
    bus.xfer_req_i = 1'b1;
    tick(); settle();
    check_eq("unc_claim_flags", 32'(xfer_flags()), 32'h0);
    tick(); tick();
    bus.hnd_gnt_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      settle();
      check_eq($sformatf("stall_flags%0d", k), 32'(xfer_flags()), 32'h0C);
      check_eq($sformatf("stall_hreq%0d", k), 32'(bus.hnd_req_o), 32'h0);
      tick();
    end
    bus.xfer_req_i = 1'b0;
    settle();
    check_eq("stall_reqfall", 32'(xfer_flags()), 32'h0C);
    tick(); settle();
    check_eq("stall_end_flags", 32'(xfer_flags()), 32'h0);
    check_eq("stall_end_busy", 32'(busy_o), 32'h0);

    // One-cycle request pulse aborts the claim window.
    bus.xfer_req_i  = 1'b1;
    bus.hnd_claim_i = 3'b001;
    tick();
    bus.xfer_req_i = 1'b0;
    settle();
    check_eq("pulse_busy", 32'(busy_o), 32'h1);
    check_eq("pulse_flags", 32'(xfer_flags()), 32'h0);
    check_eq("pulse_hreq", 32'(bus.hnd_req_o), 32'h0);
    tick(); settle();
    check_eq("pulse_idle", 32'(busy_o), 32'h0);
    check_eq("pulse_hreq_idle", 32'(bus.hnd_req_o), 32'h0);
    check_eq("pulse_flags_idle", 32'(xfer_flags()), 32'h0);
    idle_inputs();
    tick();

    // 64-byte IN transfer from handler 0 with tready toggling 1010...
    bus.xfer_req_i  = 1'b1;
    bus.hnd_claim_i = 3'b101;
    tick(); tick(); tick();
    bus.hnd_claim_i = 3'b000;
    bus.hnd_gnt_i   = 3'b001;
    settle();
    check_eq("bp_owner", 32'(owner_o), 32'h0);
    ptr = 0; got = 0; bad = 0; cyc = 0;
    while (ptr < 64 && cyc < 300) begin
      bus.hnd_tvalid_i      = 3'b101;
      bus.hnd_tlast_i[0]    = (ptr == 63);
      bus.hnd_tdata_i[7:0]  = 8'(ptr * 7 + 3);
      bus.hnd_tdata_i[23:16] = 8'h5A;
      bus.xfer_tready_i     = (cyc % 2 == 0);
      settle();
      if (bus.xfer_tvalid_o && bus.xfer_tready_i) begin
        if (bus.xfer_tdata_o !== 8'(got * 7 + 3)) bad++;
        if (bus.xfer_tlast_o !== (got == 63)) bad++;
        got++;
      end
      adv = bus.hnd_tready_o[0] & bus.hnd_tvalid_i[0];
      tick();
      if (adv) ptr++;
      cyc++;
    end
    check_eq("bp_beats", 32'(got), 32'd64);
    check_eq("bp_bad", 32'(bad), 32'd0);
    check_eq("bp_cycles", 32'(cyc), 32'd127);
    idle_inputs();
    tick(); tick();

    // Owner that never grants.
    bus.xfer_req_i  = 1'b1;
    bus.hnd_claim_i = 3'b001;
    tick(); tick(); tick();
    settle();
    check_eq("wd_own_hreq", 32'(bus.hnd_req_o), 32'h1);
`ifdef USB_CTL_ARB_WATCHDOG_EN
    repeat (14) tick();
    settle();
    check_eq("wd_c15_hreq", 32'(bus.hnd_req_o), 32'h1);
    check_eq("wd_c15_stall", 32'(bus.xfer_stall_o), 32'h0);
    tick(); settle();
    check_eq("wd_c16_hreq", 32'(bus.hnd_req_o), 32'h0);
    tick(); settle();
    check_eq("wd_stall_flags", 32'(xfer_flags()), 32'h0C);
`else
    repeat (1000) tick();
    settle();
    check_eq("nowd_hreq", 32'(bus.hnd_req_o), 32'h1);
    check_eq("nowd_busy", 32'(busy_o), 32'h1);
    check_eq("nowd_stall", 32'(bus.xfer_stall_o), 32'h0);
`endif
    idle_inputs();
    tick(); tick();

    // Asynchronous reset in the middle of OWN.
    bus.xfer_req_i  = 1'b1;
    bus.hnd_claim_i = 3'b010;
    tick(); tick(); tick();
    bus.hnd_gnt_i    = 3'b010;
    bus.hnd_tvalid_i = 3'b010;
    settle();
    check_eq("mrst_pre_hreq", 32'(bus.hnd_req_o), 32'h2);
    reset_n = 1'b0;
    settle();
    check_eq("mrst_owner", 32'(owner_o), 32'h0);
    check_eq("mrst_busy", 32'(busy_o), 32'h0);
    check_eq("mrst_hreq", 32'(bus.hnd_req_o), 32'h0);
    check_eq("mrst_flags", 32'(xfer_flags()), 32'h0);
    check_eq("mrst_tready", 32'(bus.hnd_tready_o), 32'h0);
    idle_inputs();
    tick();
    reset_n = 1'b1;
    tick(); settle();
    check_eq("mrst_after_busy", 32'(busy_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/usb_ctl_arbiter.md
# usb_ctl_arbiter

Parametrised N-way arbiter between the USB transfer layer's control-endpoint port and a set of control-request handlers: the standard-request responder, vendor/class handlers and the user control port. It generalises the fixed two-way "standard vs user" control mux into a registered claim/ownership protocol with priority selection and STALL on unclaimed requests. It sits between `usb_xfer` (upstream) and the handlers (downstream); all handlers see the decoded SETUP fields directly.

## Interface
- `N_HND`, 2: number of handlers, 2..8; index 0 has highest priority.
- `CLAIM_CYCLES`, 2: cycles after request rise over which claims are sampled, 1..15.
- `GNT_TIMEOUT`, 1024: owner-accept watchdog limit in cycles; used only with the watchdog macro; 16-bit.
- `clock`  in  1  USB clock (60 MHz ULPI clock).
- `reset_n`  in  1  asynchronous, active-low reset.
- `xfer_req_i`  in  1  control transfer pending (SETUP decoded), held high until the transfer ends.
- `xfer_gnt_o`  out  1  accept to `usb_xfer`.
- `xfer_done_o`  out  1  status-stage done to `usb_xfer`.
- `xfer_stall_o`  out  1  request unclaimed or aborted; `usb_xfer` answers STALL.
- `xfer_dvalid_i`  in  1  OUT data-stage byte valid (data bus goes directly to all handlers).
- `xfer_tvalid_o`, `xfer_tlast_o`  out  1  IN data-stage stream.
- `xfer_tdata_o`  out  8  IN data-stage stream.
- `xfer_tready_i`  in  1  IN stream ready.
- `hnd_claim_i`  in  N_HND  handler i recognises the current SETUP.
- `hnd_req_o`  out  N_HND  request forwarded to the owner only.
- `hnd_gnt_i`, `hnd_done_i`  in  N_HND  per-handler accept/done.
- `hnd_dvalid_o`  out  N_HND  OUT byte valid, owner only.
- `hnd_tvalid_i`, `hnd_tlast_i`  in  N_HND  per-handler IN stream.
- `hnd_tdata_i`  in  8*N_HND  handler i on bits [8i+7:8i].
- `hnd_tready_o`  out  N_HND  IN ready, owner only.
- `owner_o`  out  3  current owner index.
- `busy_o`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, CLAIM, OWN, STALL; encoded in registers, cleared asynchronously by `reset_n` low.
- IDLE: on `xfer_req_i`=1 go to CLAIM with `cnt`=0.
- CLAIM: `cnt` increments each cycle; `hnd_claim_i` is OR-accumulated into `claim_q`. When `cnt`=CLAIM_CYCLES-1: if `claim_q|hnd_claim_i` is nonzero, latch `owner` = lowest set index and go to OWN; otherwise go to STALL. If `xfer_req_i` falls during CLAIM, return to IDLE; no outputs assert.
- OWN: `hnd_req_o[owner]`=`xfer_req_i`; `xfer_gnt_o`=`hnd_gnt_i[owner]`; `xfer_done_o`=`hnd_done_i[owner]`; the IN stream and `hnd_dvalid_o` route to and from the owner only. Non-owners see req/tready/dvalid=0. Go to IDLE when `xfer_req_i`=0.
- STALL: `xfer_stall_o`=1, `xfer_done_o`=1, `xfer_gnt_o`=0; go to IDLE when `xfer_req_i`=0.
- Multiple simultaneous claimants resolve to the lowest index. Claims arriving after the decision are ignored.
- A new `xfer_req_i` rise is accepted only from IDLE, which enforces at least one IDLE cycle between transfers.

## Timing
- Reset values: all outputs 0; `owner_o`=0; `claim_q`=0.
- Ownership decision: the OWN/STALL state is visible CLAIM_CYCLES+1 edges after `xfer_req_i` rises.
- In OWN, routing of gnt, done, tvalid, tlast, tdata, tready and dvalid is combinational from the registered `owner`. There is zero added stream latency and no buffering.
- Stream rule: a beat transfers when `xfer_tvalid_o` and `xfer_tready_i` are both 1. `owner` never changes mid-stream.
- `xfer_req_i` falling in OWN: `hnd_req_o` drops in the same cycle and the state is IDLE at the next edge. An in-flight IN beat is discarded.

## Configuration
- Macro: `USB_CTL_ARB_WATCHDOG_EN`.
- Defined:
  - A 16-bit counter runs in OWN while `hnd_gnt_i[owner]`=0.
  - On reaching GNT_TIMEOUT-1, the FSM goes to STALL and `hnd_req_o[owner]` drops.
  - The counter clears on entering OWN.
- Undefined: no counter; OWN waits indefinitely for the owner's accept.

## Test plan
- Reset: hold `reset_n`=0 mid-OWN -> all outputs 0 immediately and FSM in IDLE; after release, `busy_o`=0.
- N_HND=3, CLAIM_CYCLES=2:
  - Handlers 1 and 2 both claim -> `owner_o`=1 at cycle 3; 18-byte IN stream from handler 1 appears on `xfer_tdata_o` with tlast on byte 18.
  - Handler 2's tready stays 0 throughout.
- Unclaimed request -> `xfer_stall_o`=1 and `xfer_done_o`=1 from cycle 3 until `xfer_req_i` falls; all `hnd_req_o`=0 throughout.
- `xfer_req_i` pulsed for 1 cycle (CLAIM_CYCLES=2) -> return to IDLE; no gnt, stall or hnd_req asserted.
- Backpressure: `xfer_tready_i` toggled 1010… over a 64-byte IN transfer -> exactly 64 beats in order, with no duplicates or drops.
- With `USB_CTL_ARB_WATCHDOG_EN` and GNT_TIMEOUT=16, owner never grants -> STALL entered on the 16th OWN cycle; without the macro the FSM is still in OWN after 1000 cycles.
